// File: rtl/tf_pair_aligner7.sv
// tf_pair_aligner7: pairs butterfly samples with provider twiddles; `define TF_ALIGN_CHECK_EN adds sticky align_err
module tf_pair_aligner7 #(
  parameter int float_len      = 32,
  parameter int fifo_addr_len  = 2,
  parameter int frame_addr_len = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*float_len-1:0] data_in,
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  output logic                   tf_en,
  input  logic [2*float_len-1:0] tf_in,
  input  logic                   tf_in_valid,
  output logic [2*float_len-1:0] data_out,
  output logic [2*float_len-1:0] tf_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
`ifdef TF_ALIGN_CHECK_EN
  ,output logic                  align_err
`endif
);
  localparam int w = 2 * float_len;
  localparam logic [fifo_addr_len:0] depth = {1'b1, {fifo_addr_len{1'b0}}};
  logic [w-1:0] dmem [2**fifo_addr_len];
  logic [w-1:0] tmem [2**fifo_addr_len];
  logic [fifo_addr_len-1:0] dwp, drp, twp, trp;
  logic [fifo_addr_len:0] dcnt, tcnt, tf_pend;
  logic [frame_addr_len-1:0] fcnt;
  logic accept, t_ok, t_push, t_ret, load;
  logic [w-1:0] t_head;
  // twiddle space is reserved at request time because the provider cannot stall
  assign data_in_ready = rst & (dcnt < depth) & (({1'b0, tcnt} + {1'b0, tf_pend}) < {1'b0, depth});
  assign accept = data_in_valid & data_in_ready;
  assign tf_en = accept;
  assign t_ret = tf_in_valid & (tf_pend != '0);
`ifdef TF_ALIGN_CHECK_EN
  assign t_ok = t_ret;
  assign t_push = t_ok & ((tcnt != depth) | load);
`else
  assign t_ok = tf_in_valid;
  assign t_push = t_ok;
`endif
  // a twiddle arriving into an empty FIFO is forwarded straight to the output register
  assign load = (dcnt != '0) & ((tcnt != '0) | t_ok) & (!out_valid | out_ready);
  assign t_head = (tcnt != '0) ? tmem[trp] : tf_in;
  always_ff @(posedge clk) begin
    if (accept) dmem[dwp] <= data_in;
    if (t_push) tmem[twp] <= tf_in;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwp <= '0;
      drp <= '0;
      twp <= '0;
      trp <= '0;
      dcnt <= '0;
      tcnt <= '0;
      tf_pend <= '0;
      fcnt <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      data_out <= '0;
      tf_out <= '0;
    end else begin
      dwp <= dwp + fifo_addr_len'(accept);
      drp <= drp + fifo_addr_len'(load);
      twp <= twp + fifo_addr_len'(t_push);
      trp <= trp + fifo_addr_len'(load);
      dcnt <= dcnt + (fifo_addr_len+1)'(accept) - (fifo_addr_len+1)'(load);
      tcnt <= tcnt + (fifo_addr_len+1)'(t_push) - (fifo_addr_len+1)'(load);
      tf_pend <= tf_pend + (fifo_addr_len+1)'(accept) - (fifo_addr_len+1)'(t_ret);
      if (load) begin
        out_valid <= 1'b1;
        data_out <= dmem[drp];
        tf_out <= t_head;
        out_last <= &fcnt;
        fcnt <= fcnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
`ifdef TF_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) align_err <= 1'b0;
    else align_err <= align_err | (tf_in_valid & (tf_pend == '0)) | (t_ok & (tcnt == depth) & !load);
  end
`endif
endmodule

// File: tb/tb_tf_pair_aligner7.sv
// tb_tf_pair_aligner7: directed streams against a queue-based pairing model with a provider model
module tb_tf_pair_aligner7;
  typedef struct { logic [63:0] d; int idx; } pair_t;
  logic clk = 0;
  logic rst = 1;
  logic [63:0] data_in = '0;
  logic data_in_valid = 0, data_in_ready, tf_en;
  logic [63:0] tf_in, ptf, data_out, tf_out;
  logic tf_in_valid, pv, inj = 0;
  logic out_valid, out_ready = 1, out_last;
`ifdef TF_ALIGN_CHECK_EN
  logic align_err;
`endif
  int paddr, checks = 0, errors = 0, acc_cnt = 0, next_k = 0, cyc = 0;
  int pops = 0, first_pop = -1, last_pop = -1, last_cnt = 0, last_idx = -1;
  pair_t exp_q[$];

  tf_pair_aligner7 dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .tf_en(tf_en), .tf_in(tf_in), .tf_in_valid(tf_in_valid),
    .data_out(data_out), .tf_out(tf_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
`ifdef TF_ALIGN_CHECK_EN
    , .align_err(align_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // twiddle provider: returns twiddle (read index + 100) one cycle after each enable
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= 0;
      paddr <= 0;
      ptf <= '0;
    end else begin
      pv <= tf_en;
      if (tf_en) begin
        ptf <= 64'(paddr) + 64'd100;
        paddr <= paddr + 1;
      end
    end
  end
  assign tf_in = inj ? 64'hBAD0_BAD0_BAD0_BAD0 : ptf;
  assign tf_in_valid = pv | inj;

  function automatic logic [63:0] dval(int k);
    return {32'(k) ^ 32'h5a5a_0000, 32'(k)};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) if (rst) begin
    chk("tf_en_is_accept", 64'(tf_en), 64'(data_in_valid & data_in_ready));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_pair actual=%h required=none", data_out);
      end else begin
        chk("pair_data", data_out, exp_q[0].d);
        chk("pair_tf", tf_out, 64'(exp_q[0].idx) + 64'd100);
        chk("pair_last", 64'(out_last), 64'(exp_q[0].idx % 8192 == 8191));
        if (out_ready) begin
          if (out_last) begin
            last_cnt++;
            last_idx = exp_q[0].idx;
          end
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
          pops++;
          void'(exp_q.pop_front());
        end
      end
    end
    if (data_in_valid && data_in_ready) begin
      exp_q.push_back('{data_in, acc_cnt});
      acc_cnt++;
    end
    chk("occupancy_bound", 64'(exp_q.size() <= 5), 64'd1);
  end

  task automatic do_reset();
    data_in_valid = 1;
    data_in = {$urandom, $urandom};
    out_ready = 1'($urandom);
    rst = 0;
    #1;
    chk("rst_data_in_ready", 64'(data_in_ready), 64'd0);
    chk("rst_tf_en", 64'(tf_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_tf_out", tf_out, 64'd0);
`ifdef TF_ALIGN_CHECK_EN
    chk("rst_align_err", 64'(align_err), 64'd0);
`endif
    exp_q.delete();
    acc_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    data_in_valid = 0;
    out_ready = 1;
    rst = 1;
    @(negedge clk);
    chk("post_rst_ready", 64'(data_in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic stream(int n);
    int sent = 0, budget = 0;
    logic a;
    while (sent < n && budget < n * 4 + 100) begin
      data_in_valid = 1;
      data_in = dval(next_k);
      @(negedge clk);
      a = data_in_ready;
      @(posedge clk);
      #1;
      if (a) begin
        sent++;
        next_k++;
      end
      budget++;
    end
    data_in_valid = 0;
    chk("stream_sent", 64'(sent), 64'(n));
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    do_reset();
    // streaming with hand-checked latency and first pair
    pops = 0;
    first_pop = -1;
    fork
      stream(16);
      begin
        @(negedge clk);
        chk("first_tf_en", 64'(tf_en), 64'd1);
        @(negedge clk);
        chk("lat_n1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_n2_out_valid", 64'(out_valid), 64'd1);
        chk("first_data", data_out, 64'h5a5a_0000_0000_0000);
        chk("first_tf", tf_out, 64'd100);
      end
    join
    drain();
    chk("stream_pairs", 64'(pops), 64'd16);
    chk("no_bubbles", 64'(last_pop - first_pop), 64'd15);
    // backpressure
    fork
      stream(20);
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_ready_low", 64'(data_in_ready), 64'd0);
        chk("stall_buffered", 64'(exp_q.size()), 64'd5);
        @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    drain();
    chk("bp_pairs", 64'(pops), 64'd36);
    // frame wrap
    do_reset();
    last_cnt = 0;
    stream(8194);
    drain();
    chk("wrap_last_count", 64'(last_cnt), 64'd1);
    chk("wrap_last_idx", 64'(last_idx), 64'd8191);
    // mid-stream reset with pairs buffered
    out_ready = 0;
    stream(3);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_buffered", 64'(exp_q.size()), 64'd3);
    do_reset();
    last_cnt = 0;
    last_idx = -1;
    stream(8193);
    drain();
    chk("mid_last_count", 64'(last_cnt), 64'd1);
    chk("mid_last_idx", 64'(last_idx), 64'd8191);
`ifdef TF_ALIGN_CHECK_EN
    inj = 1;
    @(posedge clk);
    #1;
    inj = 0;
    @(negedge clk);
    chk("align_err_set", 64'(align_err), 64'd1);
    chk("align_no_pair", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("align_err_held", 64'(align_err), 64'd1);
    @(posedge clk);
    #1;
    stream(4);
    drain();
    chk("align_err_still", 64'(align_err), 64'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
